turn_sequencer: RTL and testbench

Top-level phase controller for the game. It steps the menu, player and enemy sub-blocks through rounds and detects rising edges on their finished levels. It keeps player/enemy hit points, issues one-cycle start pulses and round resets, and drives the 4-bit state code used by the pixel mux. It replaces the ad hoc state register in the game top level.

---
 rtl/turn_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_turn_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turn_sequencer.sv
// turn_sequencer: menu / player / enemy round controller with HP tracking.
// Optional `TURN_TIMEOUT_EN: frame-based player turn timeout.
module turn_sequencer #(
  parameter logic [7:0]  PLAYER_HP_INIT      = 8'd100,
  parameter logic [7:0]  ENEMY_HP_INIT       = 8'd100,
  parameter logic [15:0] TURN_TIMEOUT_FRAMES = 16'd1800
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_frame_in,
  input  logic       menu_finish_in,
  input  logic       player_finish_in,
  input  logic       enemy_finish_in,
  input  logic [7:0] player_dmg_in,
  input  logic [7:0] enemy_dmg_in,
  output logic [3:0] state_out,
  output logic       start_out,
  output logic       round_rst_out,
  output logic [7:0] player_hp_out,
  output logic [7:0] enemy_hp_out,
  output logic [7:0] round_out,
  output logic       winner_out
);

  typedef enum logic [2:0] {
    S_MENU,
    S_PLAYER,
    S_P_RES,
    S_ENEMY,
    S_E_RES,
    S_ROUND_END,
    S_OVER
  } state_t;

  localparam logic [3:0] CODE_MENU   = 4'b0000;
  localparam logic [3:0] CODE_PLAYER = 4'b0001;
  localparam logic [3:0] CODE_ENEMY  = 4'b1000;
  localparam logic [3:0] CODE_OVER   = 4'b0010;

  state_t     st;
  logic       menu_q;
  logic       player_q;
  logic       enemy_q;
  logic       menu_ev;
  logic       player_ev;
  logic       enemy_ev;
  logic       boot;
  logic [7:0] dmg;
  logic [7:0] ehp_next;
  logic [7:0] php_next;
  logic       timeout;

  function automatic logic [7:0] sat_sub(
    input logic [7:0] hp,
    input logic [7:0] d
  );
    return (d >= hp) ? 8'd0 : hp - d;
  endfunction

  assign ehp_next = sat_sub(enemy_hp_out, dmg);
  assign php_next = sat_sub(player_hp_out, dmg);

  // Registered rising-edge detectors on the sub-block finish levels
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      menu_q    <= 1'b0;
      player_q  <= 1'b0;
      enemy_q   <= 1'b0;
      menu_ev   <= 1'b0;
      player_ev <= 1'b0;
      enemy_ev  <= 1'b0;
    end else begin
      menu_q    <= menu_finish_in;
      player_q  <= player_finish_in;
      enemy_q   <= enemy_finish_in;
      menu_ev   <= menu_finish_in & ~menu_q;
      player_ev <= player_finish_in & ~player_q;
      enemy_ev  <= enemy_finish_in & ~enemy_q;
    end
  end

`ifdef TURN_TIMEOUT_EN
  logic [15:0] frame_cnt;

  assign timeout = (frame_cnt == TURN_TIMEOUT_FRAMES);

  // Frames spent in the current player turn; zero whenever outside PLAYER
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= 16'd0;
    end else if (st != S_PLAYER) begin
      frame_cnt <= 16'd0;
    end else if (new_frame_in && !timeout) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`else
  logic unused_ok;

  assign timeout   = 1'b0;
  assign unused_ok = &{1'b0, new_frame_in, TURN_TIMEOUT_FRAMES};
`endif

  // Phase FSM with registered state code, pulses, HP and round count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st            <= S_MENU;
      state_out     <= CODE_MENU;
      start_out     <= 1'b0;
      round_rst_out <= 1'b0;
      player_hp_out <= PLAYER_HP_INIT;
      enemy_hp_out  <= ENEMY_HP_INIT;
      round_out     <= 8'd0;
      winner_out    <= 1'b0;
      dmg           <= 8'd0;
      boot          <= 1'b1;
    end else begin
      boot          <= 1'b0;
      start_out     <= boot;
      round_rst_out <= 1'b0;
      unique case (st)
        S_MENU: begin
          if (menu_ev) begin
            st            <= S_PLAYER;
            state_out     <= CODE_PLAYER;
            start_out     <= 1'b1;
            player_hp_out <= PLAYER_HP_INIT;
            enemy_hp_out  <= ENEMY_HP_INIT;
          end
        end
        S_PLAYER: begin
          if (player_ev) begin
            dmg <= player_dmg_in;
            st  <= S_P_RES;
          end else if (timeout) begin
            dmg <= 8'd0;
            st  <= S_P_RES;
          end
        end
        S_P_RES: begin
          enemy_hp_out <= ehp_next;
          if (ehp_next == 8'd0) begin
            st         <= S_OVER;
            state_out  <= CODE_OVER;
            winner_out <= 1'b1;
          end else begin
            st        <= S_ENEMY;
            state_out <= CODE_ENEMY;
            start_out <= 1'b1;
          end
        end
        S_ENEMY: begin
          if (enemy_ev) begin
            dmg <= enemy_dmg_in;
            st  <= S_E_RES;
          end
        end
        S_E_RES: begin
          player_hp_out <= php_next;
          if (php_next == 8'd0) begin
            st         <= S_OVER;
            state_out  <= CODE_OVER;
            winner_out <= 1'b0;
          end else begin
            st            <= S_ROUND_END;
            state_out     <= CODE_ENEMY;
            round_rst_out <= 1'b1;
          end
        end
        S_ROUND_END: begin
          if (round_out != 8'hFF) begin
            round_out <= round_out + 8'd1;
          end
          st        <= S_PLAYER;
          state_out <= CODE_PLAYER;
          start_out <= 1'b1;
        end
        S_OVER: begin
          if (menu_ev) begin
            st            <= S_MENU;
            state_out     <= CODE_MENU;
            start_out     <= 1'b1;
            round_rst_out <= 1'b1;
            round_out     <= 8'd0;
            winner_out    <= 1'b0;
          end
        end
        default: begin
          st        <= S_MENU;
          state_out <= CODE_MENU;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: directed game scenarios checked every cycle
// against a phase-level model plus hand-computed checkpoints.
module tb_turn_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       new_frame = 1'b0;
  logic       menu = 1'b0;
  logic       pfin = 1'b0;
  logic       efin = 1'b0;
  logic [7:0] pdmg = 8'd0;
  logic [7:0] edmg = 8'd0;
  logic [3:0] state_out;
  logic       start_out;
  logic       round_rst_out;
  logic [7:0] player_hp_out;
  logic [7:0] enemy_hp_out;
  logic [7:0] round_out;
  logic       winner_out;

  int vectors = 0;
  int miscompares = 0;
  int n_start = 0;
  int n_rr = 0;
  int n_enemy = 0;

  always #5 clk = ~clk;

  turn_sequencer #(
    .PLAYER_HP_INIT(8'd100),
    .ENEMY_HP_INIT(8'd100),
    .TURN_TIMEOUT_FRAMES(16'd3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .new_frame_in(new_frame),
    .menu_finish_in(menu),
    .player_finish_in(pfin),
    .enemy_finish_in(efin),
    .player_dmg_in(pdmg),
    .enemy_dmg_in(edmg),
    .state_out(state_out),
    .start_out(start_out),
    .round_rst_out(round_rst_out),
    .player_hp_out(player_hp_out),
    .enemy_hp_out(enemy_hp_out),
    .round_out(round_out),
    .winner_out(winner_out)
  );

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp,
               $time);
    end
  endtask

  // ---------------- phase-level model ----------------
  localparam int PM = 0, PP = 1, PPR = 2, PE = 3;
  localparam int PER = 4, PRE = 5, PO = 6;
`ifdef TURN_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  int         ph;
  int         m_frames;
  logic [7:0] m_php, m_ehp, m_rnd, m_dmg;
  logic       m_win, m_start, m_rr, m_boot;
  logic [2:0] m_prev, m_ev, m_fire, m_cur;

  function automatic logic [7:0] hit(input logic [7:0] hp,
                                     input logic [7:0] d);
    return (d >= hp) ? 8'd0 : hp - d;
  endfunction

  function automatic logic [3:0] code_of(input int p);
    case (p)
      PP, PPR:       return 4'b0001;
      PE, PER, PRE:  return 4'b1000;
      PO:            return 4'b0010;
      default:       return 4'b0000;
    endcase
  endfunction

  task automatic m_reset();
    ph = PM; m_frames = 0;
    m_php = 8'd100; m_ehp = 8'd100; m_rnd = 8'd0; m_dmg = 8'd0;
    m_win = 1'b0; m_start = 1'b0; m_rr = 1'b0; m_boot = 1'b1;
    m_prev = 3'b000; m_ev = 3'b000;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_reset();
      end else begin
        m_cur   = {efin, pfin, menu};
        m_fire  = m_ev;
        m_ev    = m_cur & ~m_prev;
        m_prev  = m_cur;
        m_start = m_boot;
        m_boot  = 1'b0;
        m_rr    = 1'b0;
        case (ph)
          PM: if (m_fire[0]) begin
            ph = PP; m_start = 1'b1; m_frames = 0;
            m_php = 8'd100; m_ehp = 8'd100;
          end
          PP: begin
            if (m_fire[1]) begin
              m_dmg = pdmg; ph = PPR;
            end else if (TO_ON && m_frames == 3) begin
              m_dmg = 8'd0; ph = PPR;
            end else if (new_frame) begin
              m_frames++;
            end
          end
          PPR: begin
            m_ehp = hit(m_ehp, m_dmg);
            if (m_ehp == 0) begin ph = PO; m_win = 1'b1; end
            else begin ph = PE; m_start = 1'b1; end
          end
          PE: if (m_fire[2]) begin m_dmg = edmg; ph = PER; end
          PER: begin
            m_php = hit(m_php, m_dmg);
            if (m_php == 0) begin ph = PO; m_win = 1'b0; end
            else begin ph = PRE; m_rr = 1'b1; end
          end
          PRE: begin
            if (m_rnd != 8'd255) m_rnd++;
            ph = PP; m_start = 1'b1; m_frames = 0;
          end
          default: if (m_fire[0]) begin
            ph = PM; m_start = 1'b1; m_rr = 1'b1;
            m_rnd = 8'd0; m_win = 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("state", {4'd0, state_out}, {4'd0, code_of(ph)});
      chk("start", {7'd0, start_out}, {7'd0, m_start});
      chk("round_rst", {7'd0, round_rst_out}, {7'd0, m_rr});
      chk("player_hp", player_hp_out, m_php);
      chk("enemy_hp", enemy_hp_out, m_ehp);
      chk("round", round_out, m_rnd);
      if (ph == PO) chk("winner", {7'd0, winner_out}, {7'd0, m_win});
      if (start_out) n_start++;
      if (round_rst_out) n_rr++;
      if (state_out == 4'b1000) n_enemy++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic fin(input int which, input logic [7:0] d);
    pdmg = d;
    edmg = d;
    case (which)
      0:       menu = 1'b1;
      1:       pfin = 1'b1;
      default: efin = 1'b1;
    endcase
    step(5);
    menu = 1'b0;
    pfin = 1'b0;
    efin = 1'b0;
    step(3);
  endtask

  int base;

  initial begin
    #1 rst = 1'b0;
    step(2);
    chk("rst_state", {4'd0, state_out}, 8'd0);
    chk("rst_start", {7'd0, start_out}, 8'd0);
    chk("rst_php", player_hp_out, 8'd100);
    chk("rst_round", round_out, 8'd0);
    rst = 1'b1;
    step(1);
    chk("boot_start", {7'd0, start_out}, 8'd1);

    step(1);
    base = n_start;
    menu = 1'b1;
    step(3);
    menu = 1'b0;
    step(3);
    chk("menu_state", {4'd0, state_out}, 8'd1);
    chk("menu_starts", 8'(n_start - base), 8'd1);
    chk("menu_ehp", enemy_hp_out, 8'd100);

    base = n_rr;
    fin(1, 8'd30);
    chk("p30_ehp", enemy_hp_out, 8'd70);
    fin(2, 8'd20);
    chk("e20_php", player_hp_out, 8'd80);
    chk("r1_round", round_out, 8'd1);
    chk("r1_rr", 8'(n_rr - base), 8'd1);
    chk("r1_state", {4'd0, state_out}, 8'd1);

    base = n_enemy;
    fin(1, 8'd120);
    chk("kill_ehp", enemy_hp_out, 8'd0);
    chk("kill_state", {4'd0, state_out}, 8'd2);
    chk("kill_win", {7'd0, winner_out}, 8'd1);
    chk("kill_no_enemy", 8'(n_enemy - base), 8'd0);
    fin(0, 8'd0);
    chk("over_menu", {4'd0, state_out}, 8'd0);
    chk("over_round", round_out, 8'd0);

    fin(0, 8'd0);
    fin(2, 8'd50);
    chk("ign_state", {4'd0, state_out}, 8'd1);
    chk("ign_php", player_hp_out, 8'd100);
    pdmg = 8'd10;
    edmg = 8'd77;
    pfin = 1'b1;
    efin = 1'b1;
    step(6);
    chk("both_state", {4'd0, state_out}, 8'd8);
    chk("both_ehp", enemy_hp_out, 8'd90);
    chk("both_php", player_hp_out, 8'd100);
    pfin = 1'b0;
    efin = 1'b0;
    step(3);

    fin(2, 8'd0);
    chk("e0_php", player_hp_out, 8'd100);
    fin(1, 8'd80);
    fin(2, 8'd60);
    fin(1, 8'd0);
    chk("pre_rst_php", player_hp_out, 8'd40);
    chk("pre_rst_ehp", enemy_hp_out, 8'd10);
    chk("pre_rst_round", round_out, 8'd2);

    step(1);
    #2 rst = 1'b0;
    #1;
    chk("arst_state", {4'd0, state_out}, 8'd0);
    chk("arst_php", player_hp_out, 8'd100);
    chk("arst_ehp", enemy_hp_out, 8'd100);
    chk("arst_start", {7'd0, start_out}, 8'd0);
    chk("arst_rr", {7'd0, round_rst_out}, 8'd0);
    step(2);
    rst = 1'b1;
    step(1);
    chk("arst_boot", {7'd0, start_out}, 8'd1);

    fin(0, 8'd0);
    fin(1, 8'd5);
    fin(2, 8'd200);
    chk("lose_php", player_hp_out, 8'd0);
    chk("lose_ehp", enemy_hp_out, 8'd95);
    chk("lose_state", {4'd0, state_out}, 8'd2);
    chk("lose_win", {7'd0, winner_out}, 8'd0);

`ifdef TURN_TIMEOUT_EN
    fin(0, 8'd0);
    fin(0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      new_frame = 1'b1;
      step(1);
      new_frame = 1'b0;
      step(1);
    end
    step(3);
    chk("to_state", {4'd0, state_out}, 8'd8);
    chk("to_ehp", enemy_hp_out, 8'd100);
`endif

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
